// File: rtl/reloj_mmss_7seg.sv
// MM:SS up/down timer driven by an asynchronous 1 Hz input.
// Outputs are BCD digits plus 7-segment patterns for each digit.
module reloj_mmss_7seg #(
  parameter int MAX_MIN        = 59,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       C_50Mhz,
  input  logic       rst,
  input  logic       C_1Hz,
  input  logic       run,
  input  logic       clear,
  input  logic       down,
  output logic       tick,
  output logic       wrap,
  output logic [3:0] sec_u,
  output logic [3:0] sec_d,
  output logic [3:0] min_u,
  output logic [3:0] min_d,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3
);

  localparam logic [3:0] MAX_MD  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MU  = 4'(MAX_MIN % 10);
  localparam logic [6:0] MAX_VAL = 7'(MAX_MIN);

  logic       s0_q, s1_q, prev_q, tick_q;
  logic       wrap_q, wrap_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [3:0] sec_d_q, sec_d_d;
  logic [3:0] min_u_q, min_u_d;
  logic [3:0] min_d_q, min_d_d;
  logic [6:0] min_val;

  // Sync chain resets high so a level already high at release is not an edge.
  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s0_q   <= C_1Hz;
      s1_q   <= s0_q;
      prev_q <= s1_q;
      tick_q <= s1_q & ~prev_q;
    end
  end

  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      sec_u_q <= 4'd0;
      sec_d_q <= 4'd0;
      min_u_q <= 4'd0;
      min_d_q <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      sec_u_q <= sec_u_d;
      sec_d_q <= sec_d_d;
      min_u_q <= min_u_d;
      min_d_q <= min_d_d;
      wrap_q  <= wrap_d;
    end
  end

  // Minute wrap uses the combined value so MAX_MIN need not end in 9.
  assign min_val = 7'(min_d_q) * 7'd10 + 7'(min_u_q);

  always_comb begin
    sec_u_d = sec_u_q;
    sec_d_d = sec_d_q;
    min_u_d = min_u_q;
    min_d_d = min_d_q;
    wrap_d  = 1'b0;
    if (clear) begin
      sec_u_d = 4'd0;
      sec_d_d = 4'd0;
      min_u_d = 4'd0;
      min_d_d = 4'd0;
    end else if (tick_q && run) begin
      if (!down) begin
        if (sec_u_q != 4'd9) begin
          sec_u_d = sec_u_q + 4'd1;
        end else begin
          sec_u_d = 4'd0;
          if (sec_d_q != 4'd5) begin
            sec_d_d = sec_d_q + 4'd1;
          end else begin
            sec_d_d = 4'd0;
            if (min_val == MAX_VAL) begin
              min_u_d = 4'd0;
              min_d_d = 4'd0;
              wrap_d  = 1'b1;
            end else if (min_u_q != 4'd9) begin
              min_u_d = min_u_q + 4'd1;
            end else begin
              min_u_d = 4'd0;
              min_d_d = min_d_q + 4'd1;
            end
          end
        end
      end else begin
        if (sec_u_q != 4'd0) begin
          sec_u_d = sec_u_q - 4'd1;
        end else begin
          sec_u_d = 4'd9;
          if (sec_d_q != 4'd0) begin
            sec_d_d = sec_d_q - 4'd1;
          end else begin
            sec_d_d = 4'd5;
            if (min_val == 7'd0) begin
              min_u_d = MAX_MU;
              min_d_d = MAX_MD;
              wrap_d  = 1'b1;
            end else if (min_u_q != 4'd0) begin
              min_u_d = min_u_q - 4'd1;
            end else begin
              min_u_d = 4'd9;
              min_d_d = min_d_q - 4'd1;
            end
          end
        end
      end
    end
  end

  // Active-low gfedcba patterns; codes above 9 are blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [3:0] digit_w [4];
  logic [6:0] seg_w   [4];

  assign digit_w[0] = sec_u_q;
  assign digit_w[1] = sec_d_q;
  assign digit_w[2] = min_u_q;
  assign digit_w[3] = min_d_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
      assign seg_w[gi] = SEG_ACTIVE_LOW ? seg_pattern(digit_w[gi]) : ~seg_pattern(digit_w[gi]);
    end
  endgenerate

  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign sec_u = sec_u_q;
  assign sec_d = sec_d_q;
  assign min_u = min_u_q;
  assign min_d = min_d_q;
  assign seg0  = seg_w[0];
  assign seg1  = seg_w[1];
  assign seg2  = seg_w[2];
  assign seg3  = seg_w[3];

endmodule

// File: tb/tb_reloj_mmss_7seg.sv
// Scoreboard bench for reloj_mmss_7seg: a default instance (MAX_MIN=59, active-low)
// and a short one (MAX_MIN=5, active-high) share all inputs.
module tb_reloj_mmss_7seg;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, c1hz, run, clear, down;

  logic       tick1, wrap1, tick2, wrap2;
  logic [3:0] su1, sd1, mu1, md1, su2, sd2, mu2, md2;
  logic [6:0] s10, s11, s12, s13, s20, s21, s22, s23;

  reloj_mmss_7seg #(.MAX_MIN(59), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .C_50Mhz(clk), .rst(rst), .C_1Hz(c1hz), .run(run), .clear(clear), .down(down),
    .tick(tick1), .wrap(wrap1), .sec_u(su1), .sec_d(sd1), .min_u(mu1), .min_d(md1),
    .seg0(s10), .seg1(s11), .seg2(s12), .seg3(s13));

  reloj_mmss_7seg #(.MAX_MIN(5), .SEG_ACTIVE_LOW(1'b0)) dut2 (
    .C_50Mhz(clk), .rst(rst), .C_1Hz(c1hz), .run(run), .clear(clear), .down(down),
    .tick(tick2), .wrap(wrap2), .sec_u(su2), .sec_d(sd2), .min_u(mu2), .min_d(md2),
    .seg0(s20), .seg1(s21), .seg2(s22), .seg3(s23));

  typedef struct {
    logic [15:0] d1;
    logic        w1;
    logic [15:0] d2;
    logic        w2;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int t1 = 0, t2 = 0;
  int tick_cnt = 0;
  int npulse = 0;
  localparam int N1 = 3600;
  localparam int N2 = 360;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Monitor: the cycle after a tick is when digits and wrap must update.
  initial begin
    logic tick_prev;
    logic pop_prev;
    exp_t e;
    tick_prev = 1'b0;
    pop_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (tick1) tick_cnt++;
      if (pop_prev) begin
        chk("wrap1_1cyc", 32'(wrap1), 32'd0);
        chk("wrap2_1cyc", 32'(wrap2), 32'd0);
      end
      pop_prev = 1'b0;
      if (tick_prev) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("digits1", {16'd0, md1, mu1, sd1, su1}, {16'd0, e.d1});
          chk("wrap1", 32'(wrap1), 32'(e.w1));
          chk("segs1", {4'd0, s13, s12, s11, s10},
              {4'd0, pat(e.d1[15:12]), pat(e.d1[11:8]), pat(e.d1[7:4]), pat(e.d1[3:0])});
          chk("digits2", {16'd0, md2, mu2, sd2, su2}, {16'd0, e.d2});
          chk("wrap2", 32'(wrap2), 32'(e.w2));
          chk("segs2", {4'd0, s23, s22, s21, s20},
              {4'd0, ~pat(e.d2[15:12]), ~pat(e.d2[11:8]), ~pat(e.d2[7:4]), ~pat(e.d2[3:0])});
          pop_prev = 1'b1;
        end
      end
      tick_prev = tick1;
    end
  end

  // One C_1Hz period: push expected result, then low 4 cycles, then high.
  task automatic pulse(input bit clr_on_tick);
    exp_t e;
    int   n;
    e.w1 = 1'b0;
    e.w2 = 1'b0;
    if (clr_on_tick) begin
      t1 = 0;
      t2 = 0;
    end else if (run) begin
      if (!down) begin
        e.w1 = (t1 == N1 - 1);
        e.w2 = (t2 == N2 - 1);
        t1 = (t1 + 1) % N1;
        t2 = (t2 + 1) % N2;
      end else begin
        e.w1 = (t1 == 0);
        e.w2 = (t2 == 0);
        t1 = (t1 == 0) ? N1 - 1 : t1 - 1;
        t2 = (t2 == 0) ? N2 - 1 : t2 - 1;
      end
    end
    e.d1 = bcd(t1);
    e.d2 = bcd(t2);
    sb_q.push_back(e);
    @(negedge clk);
    c1hz = 1'b0;
    repeat (4) @(negedge clk);
    c1hz = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick1 && n < 8);
    chk("tick_lat", 32'(n), 32'd3);
    if (clr_on_tick) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("tick_1cyc", 32'(tick1), 32'd0);
    npulse++;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    t1 = 0;
    t2 = 0;
    chk("clear_digits", {16'd0, md1, mu1, sd1, su1}, 32'd0);
  endtask

  initial begin
    int tc;
    rst = 1'b1; c1hz = 1'b1; run = 1'b1; clear = 1'b0; down = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits", {16'd0, md1, mu1, sd1, su1}, 32'd0);
    chk("rst_tick", 32'(tick1), 32'd0);
    chk("rst_wrap", 32'(wrap1), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_tick_high_rel", 32'(tick_cnt), 32'd0);
    chk("idle_digits", {16'd0, md1, mu1, sd1, su1}, 32'd0);
    chk("idle_seg0", 32'(s10), 32'h40);

    pulse(1'b0);
    chk("first_tick", {16'd0, md1, mu1, sd1, su1}, 32'h0001);
    chk("first_seg0", 32'(s10), 32'h79);

    for (int i = 0; i < 3598; i++) begin
      pulse(1'b0);
      if (t1 == 600) chk("carry_0959", {16'd0, md1, mu1, sd1, su1}, 32'h1000);
    end
    chk("at_5959", {16'd0, md1, mu1, sd1, su1}, 32'h5959);
    pulse(1'b0);
    chk("wrap_to_0000", {16'd0, md1, mu1, sd1, su1}, 32'h0000);

    down = 1'b1;
    pulse(1'b0);
    chk("down_wrap1", {16'd0, md1, mu1, sd1, su1}, 32'h5959);
    chk("down_wrap2", {16'd0, md2, mu2, sd2, su2}, 32'h0559);
    pulse(1'b0);
    chk("down_5958", {16'd0, md1, mu1, sd1, su1}, 32'h5958);

    clear_pulse();
    down = 1'b0;
    for (int i = 0; i < 754; i++) pulse(1'b0);
    chk("at_1234", {16'd0, md1, mu1, sd1, su1}, 32'h1234);
    pulse(1'b1);
    chk("clr_on_tick", {16'd0, md1, mu1, sd1, su1}, 32'h0000);

    run = 1'b0;
    tc = tick_cnt;
    for (int i = 0; i < 3; i++) pulse(1'b0);
    chk("hold_ticks", 32'(tick_cnt - tc), 32'd3);
    chk("hold_digits", {16'd0, md1, mu1, sd1, su1}, 32'h0000);
    run = 1'b1;

    for (int i = 0; i < 462; i++) pulse(1'b0);
    chk("at_0742", {16'd0, md1, mu1, sd1, su1}, 32'h0742);
    @(posedge clk);
    #5 rst = 1'b1;
    #2;
    chk("async_rst_digits", {16'd0, md1, mu1, sd1, su1}, 32'd0);
    chk("async_rst_seg0", 32'(s10), 32'h40);
    t1 = 0;
    t2 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tc = tick_cnt;
    repeat (10) @(negedge clk);
    chk("no_tick_after_rst", 32'(tick_cnt - tc), 32'd0);
    pulse(1'b0);
    chk("resume_0001", {16'd0, md1, mu1, sd1, su1}, 32'h0001);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("tick_total", 32'(tick_cnt), 32'(npulse));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
